// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode, state and ALU encodings for multicycle_control
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_J,
    CLS_BEQ,
    CLS_BNE,
    CLS_LW,
    CLS_SW,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_ANDI = 4'd10;
  localparam logic [3:0] OP_ORI  = 4'd11;
  localparam logic [3:0] OP_ADDI = 4'd12;
  localparam logic [3:0] OP_SLTI = 4'd13;
  localparam logic [3:0] OP_LW   = 4'd14;
  localparam logic [3:0] OP_SW   = 4'd15;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_ANDI = 4'd10;
  localparam logic [3:0] ALU_ORI  = 4'd11;
  localparam logic [3:0] ALU_SLTI = 4'd13;
  localparam logic [3:0] ALU_NOP  = 4'd0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decode: class, operand/target/writeback selects, ALU op
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int ALUW = 4
) (
  input  logic [OPW-1:0]  i_opcode,
  output op_class_t       o_class,
  output logic            o_imm_sel,
  output logic            o_jump_sel,
  output logic            o_wb_sel,
  output logic [ALUW-1:0] o_alu_op
);

  logic [3:0] w_op4;
  logic [3:0] w_alu4;
  logic       w_ext;

  assign w_op4 = i_opcode[3:0];
  // Only reachable with OPW > 4: anything above 15 is outside the instruction set.
  assign w_ext = (32'(i_opcode) > 32'd15);

  always_comb begin
    o_class   = CLS_ALU;
    o_imm_sel = 1'b0;
    w_alu4    = ALU_NOP;
    case (w_op4)
      OP_AND:  w_alu4 = ALU_AND;
      OP_OR:   w_alu4 = ALU_OR;
      OP_XOR:  w_alu4 = ALU_XOR;
      OP_NOR:  w_alu4 = ALU_NOR;
      OP_ADD:  w_alu4 = ALU_ADD;
      OP_SUB:  w_alu4 = ALU_SUB;
      OP_SLT:  w_alu4 = ALU_SLT;
      OP_J:    o_class = CLS_J;
      OP_BEQ:  o_class = CLS_BEQ;
      OP_BNE:  o_class = CLS_BNE;
      OP_ANDI: begin o_imm_sel = 1'b1; w_alu4 = ALU_ANDI; end
      OP_ORI:  begin o_imm_sel = 1'b1; w_alu4 = ALU_ORI;  end
      OP_ADDI: begin o_imm_sel = 1'b1; w_alu4 = ALU_ADD;  end
      OP_SLTI: begin o_imm_sel = 1'b1; w_alu4 = ALU_SLTI; end
      OP_LW:   o_class = CLS_LW;
      OP_SW:   o_class = CLS_SW;
      default: o_class = CLS_ALU;
    endcase
    if (w_ext) begin
      o_class   = CLS_ILLEGAL;
      o_imm_sel = 1'b0;
      w_alu4    = ALU_NOP;
    end
  end

  assign o_jump_sel = (o_class == CLS_J);
  assign o_wb_sel   = (o_class == CLS_ALU);
  assign o_alu_op   = ALUW'(w_alu4);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait timeout and sticky error flags
// CTRL_INSTRET_EN adds a retired-instruction counter output o_instret.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW          = 4,
  parameter int ALUW         = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  i_opcode,
  input  logic            i_eq,
  input  logic            i_mem_ready,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic            o_addr_sel,
  output logic            o_ir_load,
  output logic            o_pc_inc,
  output logic            o_pc_load,
  output logic            o_rf_we,
  output logic            o_jump_sel,
  output logic            o_imm_sel,
  output logic            o_wb_sel,
  output logic [ALUW-1:0] o_alu_op,
  output logic [2:0]      o_state,
  output logic            o_illegal,
  output logic            o_timeout
`ifdef CTRL_INSTRET_EN
  ,
  output logic [31:0]     o_instret
`endif
);

  localparam int WCW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t         r_state;
  state_t         w_next;
  op_class_t      w_class;
  logic [WCW-1:0] r_wait;
  logic           r_illegal;
  logic           r_timeout;
  logic           w_waiting;
  logic           w_set_illegal;

  ctrl_decode #(
    .OPW  (OPW),
    .ALUW (ALUW)
  ) u_decode (
    .i_opcode   (i_opcode),
    .o_class    (w_class),
    .o_imm_sel  (o_imm_sel),
    .o_jump_sel (o_jump_sel),
    .o_wb_sel   (o_wb_sel),
    .o_alu_op   (o_alu_op)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      // Timeout only raises the flag; the FSM keeps waiting on mem_ready.
      if (w_waiting) begin
        if (r_wait != WCW'(MEM_WAIT_MAX)) r_wait <= r_wait + 1'b1;
        if (r_wait >= WCW'(MEM_WAIT_MAX - 1)) r_timeout <= 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_addr_sel    = 1'b0;
    o_ir_load     = 1'b0;
    o_pc_inc      = 1'b0;
    o_pc_load     = 1'b0;
    o_rf_we       = 1'b0;
    w_waiting     = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req  = 1'b1;
        o_addr_sel = 1'b1;
        if (i_mem_ready) begin
          o_ir_load = 1'b1;
          o_pc_inc  = 1'b1;
          w_next    = S_DECODE;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (w_class)
          CLS_ALU:        w_next = S_WB;
          CLS_J:          o_pc_load = 1'b1;
          CLS_BEQ:        o_pc_load = i_eq;
          CLS_BNE:        o_pc_load = ~i_eq;
          CLS_LW, CLS_SW: w_next = S_MEM;
          default:        w_set_illegal = 1'b1;
        endcase
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (w_class == CLS_SW);
        if (i_mem_ready) begin
          w_next = (w_class == CLS_LW) ? S_WB : S_FETCH;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_WB: begin
        o_rf_we = 1'b1;
        w_next  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset abandons any in-flight request without waiting for the edge.
    if (!reset) begin
      o_mem_req     = 1'b0;
      o_mem_we      = 1'b0;
      o_ir_load     = 1'b0;
      o_pc_inc      = 1'b0;
      o_pc_load     = 1'b0;
      o_rf_we       = 1'b0;
      w_waiting     = 1'b0;
      w_set_illegal = 1'b0;
    end
  end

  assign o_state   = r_state;
  assign o_illegal = r_illegal;
  assign o_timeout = r_timeout;

`ifdef CTRL_INSTRET_EN
  logic [31:0] r_instret;
  logic        w_retire;

  assign w_retire = reset && (w_next == S_FETCH) &&
                    ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign o_instret = r_instret;
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPW, default 4, opcode width; legal range 4..6.
REQ-002 Parameter ALUW, default 4, ALU operation code width; SHALL be at least 4.
REQ-003 Parameter MEM_WAIT_MAX, default 15, the longest mem_ready wait (in cycles) before a timeout is flagged.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 opcode  in  OPW  opcode field of the instruction register.
REQ-007 eq  in  1  register-file comparator result, used for beq/bne.
REQ-008 mem_ready  in  1  memory completion strobe for the current mem_req.
REQ-009 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-010 addr_sel  out  1  memory address select: 1 = PC, 0 = ALU result.
REQ-011 ir_load, pc_inc, pc_load, rf_we  out  1 each  instruction-register load, PC+1, PC load from target, register-file write.
REQ-012 jump_sel, imm_sel, wb_sel  out  1 each  target select (jump/branch), ALU operand B = immediate, writeback select (1 = ALU, 0 = memory).
REQ-013 alu_op  out  ALUW  ALU operation, zero-extended from the 4-bit code.
REQ-014 state  out  3  current FSM state encoding.
REQ-015 illegal, timeout  out  1 each  sticky error flags.

Function
REQ-016 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5..7 SHALL go to FETCH on the next edge.
REQ-017 FETCH: mem_req=1, addr_sel=1; hold until mem_ready; on mem_ready pulse ir_load and pc_inc for one cycle, then go to DECODE.
REQ-018 DECODE: no enables asserted; always go to EXEC after one cycle.
REQ-019 EXEC, ALU class (opcodes 0-6, 10-13): go to WB.
REQ-020 EXEC, j (7): pc_load=1, jump_sel=1, then go to FETCH.
REQ-021 EXEC, beq (8) / bne (9): pc_load=eq / pc_load=~eq, then go to FETCH.
REQ-022 EXEC, lw (14) / sw (15): go to MEM.
REQ-023 MEM: mem_req=1, addr_sel=0, mem_we=1 only for sw; hold until mem_ready; lw goes to WB, sw goes to FETCH.
REQ-024 WB: one-cycle rf_we pulse; wb_sel=1 for the ALU class, 0 for lw; then go to FETCH.
REQ-025 Select decode, as a combinational function of opcode:
  - imm_sel=1 for opcodes 10-13.
  - alu_op: opcodes 0-6 and 10-13 map to the same code as the opcode, except addi (12), which maps to 4.
  - alu_op=0 for all other opcodes.
REQ-026 Opcode values of 16 or more (OPW>4) are illegal:
  - In EXEC, set illegal and treat the instruction as a no-op going to FETCH.
  - No enables asserted for that instruction.
REQ-027 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-028 ir_load, pc_inc, pc_load, rf_we and mem_we SHALL never be asserted in the same cycle as each other, except the ir_load+pc_inc pair.
REQ-029 Cycle counts with zero-wait memory (mem_ready in the first request cycle):
  - ALU class: 4 cycles.
  - j, beq, bne: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds 1.
REQ-030 A wait counter SHALL count consecutive FETCH/MEM cycles without mem_ready; reaching MEM_WAIT_MAX sets timeout, and the FSM keeps waiting.

Reset
REQ-031 While reset=0 at a rising edge: state goes to FETCH, illegal=0, timeout=0, wait counter=0.
REQ-032 During reset, all enables and mem_req SHALL be 0 combinationally; an in-flight memory request is abandoned.
REQ-033 Reset asserted mid-instruction SHALL discard that instruction; the first cycle after release is FETCH.

Configuration
REQ-034 Macro CTRL_INSTRET_EN:
  - Defined: adds output instret [31:0], incremented on every transition into FETCH from EXEC, MEM or WB (illegal opcodes included); wraps 0xFFFFFFFF to 0; cleared by reset.
  - Undefined: the port and its counter are absent.

Structure
REQ-035 Shared package ctrl_pkg SHALL hold:
  - opcode constants (AND..SW);
  - state encoding constants;
  - ALU operation constants.
REQ-036 Sub-module ctrl_decode SHALL hold the combinational decode (imm_sel, jump_sel, wb_sel, alu_op, opcode class); the FSM and counters stay in multicycle_control.

Verification
REQ-037 add (4), mem_ready tied 1 → states 0,1,2,4,0; ir_load and pc_inc at cycle 1; rf_we=1 and wb_sel=1 at cycle 4; alu_op=4.
REQ-038 lw (14), mem_ready delayed 3 cycles in MEM → mem_req=1 and addr_sel=0 for 4 cycles; rf_we with wb_sel=0; 8 cycles total.
REQ-039 beq (8) with eq=1, then eq=0 → pc_load=1 in EXEC for the first and 0 for the second; neither writes rf_we.
REQ-040 sw (15), then reset=0 in MEM → mem_we=1 in MEM; after reset mem_req=0 and state=0; the next fetch is unaffected.
REQ-041 OPW=5, opcode 20 → illegal=1 and no enables; sticky until reset.
REQ-042 mem_ready held 0 in FETCH for 15 cycles (MEM_WAIT_MAX=15) → timeout=1; with CTRL_INSTRET_EN, after 3 add instructions instret=3.
